// File: rtl/game_sequencer_if.sv
// Bundle of the sequencer's line-engine, board and host signals.
// master is the sequencer side; slave is the board/engine/host side.
interface game_sequencer_if;
   logic        new_game;
   logic        move_req;
   logic [1:0]  move_dir;
   logic        line_start;
   logic [1:0]  line_idx;
   logic [1:0]  line_dir;
   logic        line_done;
   logic        line_changed;
   logic [16:0] line_score;
   logic [15:0] empty_mask;
   logic        merge_possible;
   logic        clear_board;
   logic        spawn_we;
   logic [3:0]  spawn_idx;
   logic        spawn_four;
   logic [20:0] score;
   logic        busy;
   logic        move_done;
   logic        move_valid;
   logic        game_over;

   modport master (
      input  new_game, move_req, move_dir, line_done, line_changed, line_score,
             empty_mask, merge_possible,
      output line_start, line_idx, line_dir, clear_board, spawn_we, spawn_idx,
             spawn_four, score, busy, move_done, move_valid, game_over
   );

   modport slave (
      output new_game, move_req, move_dir, line_done, line_changed, line_score,
             empty_mask, merge_possible,
      input  line_start, line_idx, line_dir, clear_board, spawn_we, spawn_idx,
             spawn_four, score, busy, move_done, move_valid, game_over
   );
endinterface

// File: rtl/game_sequencer.sv
// 2048-style move sequencer: walks four lines through an external line engine,
// accumulates score, spawns tiles from an LFSR and detects game over.
module game_sequencer #(
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input logic               clk,
   input logic               rst,
   game_sequencer_if.master  bus
);

   localparam logic [15:0] SeedEff = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

   typedef enum logic [2:0] {
      StIdle, StClr, StLineGo, StLineWait, StSpawn, StCheck
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] lfsr_q, lfsr_d;
   logic [1:0]  dir_q, dir_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        changed_q, changed_d;
   logic [1:0]  spawn_cnt_q, spawn_cnt_d;
   // gap_q: in SPAWN marks the settle cycle between spawns; in CHECK marks the mask is settled
   logic        gap_q, gap_d;
   logic [15:0] excl_q, excl_d;
   logic        from_move_q, from_move_d;
   logic [20:0] score_q, score_d;
   logic        game_over_q, game_over_d;
   logic        line_start_q, line_start_d;
   logic [1:0]  line_idx_q, line_idx_d;
   logic        clear_q, clear_d;
   logic        spawn_we_q, spawn_we_d;
   logic [3:0]  spawn_idx_q, spawn_idx_d;
   logic        spawn_four_q, spawn_four_d;
   logic        busy_q, busy_d;
   logic        move_done_q, move_done_d;
   logic        move_valid_q, move_valid_d;

   logic [15:0] avail;
   logic [31:0] rot32;
   logic [15:0] rot;
   logic [3:0]  pick_off;
   logic [3:0]  pick;
   logic        found;
   logic [21:0] sum;
   logic        ch;

   // Rotate the free-cell mask so the scan origin is bit 0, then take the lowest set bit.
   always_comb begin
      avail    = bus.empty_mask & ~excl_q;
      rot32    = {avail, avail} >> lfsr_q[3:0];
      rot      = rot32[15:0];
      pick_off = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (rot[i]) pick_off = 4'(i);
      end
      found = |rot;
      pick  = lfsr_q[3:0] + pick_off;
   end

   always_comb begin
      lfsr_d       = lfsr_q[0] ? ({1'b0, lfsr_q[15:1]} ^ 16'hB400) : {1'b0, lfsr_q[15:1]};
      state_d      = state_q;
      dir_d        = dir_q;
      cnt_d        = cnt_q;
      changed_d    = changed_q;
      spawn_cnt_d  = spawn_cnt_q;
      gap_d        = gap_q;
      excl_d       = excl_q;
      from_move_d  = from_move_q;
      score_d      = score_q;
      game_over_d  = game_over_q;
      line_start_d = 1'b0;
      line_idx_d   = line_idx_q;
      clear_d      = 1'b0;
      spawn_we_d   = 1'b0;
      spawn_idx_d  = spawn_idx_q;
      spawn_four_d = spawn_four_q;
      move_done_d  = 1'b0;
      move_valid_d = 1'b0;
      sum          = {1'b0, score_q} + {5'd0, bus.line_score};
      ch           = changed_q | bus.line_changed;

      unique case (state_q)
         StIdle: begin
            if (bus.new_game) begin
               state_d     = StClr;
               clear_d     = 1'b1;
               score_d     = '0;
               game_over_d = 1'b0;
               spawn_cnt_d = 2'd2;
               excl_d      = '0;
               from_move_d = 1'b0;
            end else if (bus.move_req && !game_over_q) begin
               state_d      = StLineGo;
               dir_d        = bus.move_dir;
               changed_d    = 1'b0;
               cnt_d        = 2'd0;
               line_start_d = 1'b1;
               line_idx_d   = 2'd0;
            end
         end
         StClr: begin
            state_d = StSpawn;
            gap_d   = 1'b0;
         end
         StLineGo: state_d = StLineWait;
         StLineWait: begin
            if (bus.line_done) begin
               score_d   = sum[21] ? 21'h1FFFFF : sum[20:0];
               changed_d = ch;
               if (cnt_q != 2'd3) begin
                  cnt_d        = cnt_q + 2'd1;
                  line_idx_d   = cnt_q + 2'd1;
                  line_start_d = 1'b1;
                  state_d      = StLineGo;
               end else if (ch) begin
                  spawn_cnt_d = 2'd1;
                  excl_d      = '0;
                  from_move_d = 1'b1;
                  gap_d       = 1'b0;
                  state_d     = StSpawn;
               end else begin
                  move_done_d = 1'b1;
                  state_d     = StIdle;
               end
            end
         end
         StSpawn: begin
            if (gap_q) begin
               gap_d = 1'b0;
            end else begin
               if (found) begin
                  spawn_we_d   = 1'b1;
                  spawn_idx_d  = pick;
                  spawn_four_d = (lfsr_q[7:4] == 4'd0);
                  excl_d       = excl_q | (16'h0001 << pick);
               end
               spawn_cnt_d = spawn_cnt_q - 2'd1;
               if (spawn_cnt_q != 2'd1) begin
                  gap_d = 1'b1;
               end else begin
                  gap_d   = 1'b0;
                  state_d = StCheck;
               end
            end
         end
         StCheck: begin
            if (!gap_q) begin
               gap_d = 1'b1;
            end else begin
               game_over_d  = (bus.empty_mask == 16'h0000) && !bus.merge_possible;
               move_done_d  = from_move_q;
               move_valid_d = from_move_q;
               state_d      = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         lfsr_q       <= SeedEff;
         dir_q        <= 2'd0;
         cnt_q        <= 2'd0;
         changed_q    <= 1'b0;
         spawn_cnt_q  <= 2'd0;
         gap_q        <= 1'b0;
         excl_q       <= '0;
         from_move_q  <= 1'b0;
         score_q      <= '0;
         game_over_q  <= 1'b0;
         line_start_q <= 1'b0;
         line_idx_q   <= 2'd0;
         clear_q      <= 1'b0;
         spawn_we_q   <= 1'b0;
         spawn_idx_q  <= 4'd0;
         spawn_four_q <= 1'b0;
         busy_q       <= 1'b0;
         move_done_q  <= 1'b0;
         move_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         lfsr_q       <= lfsr_d;
         dir_q        <= dir_d;
         cnt_q        <= cnt_d;
         changed_q    <= changed_d;
         spawn_cnt_q  <= spawn_cnt_d;
         gap_q        <= gap_d;
         excl_q       <= excl_d;
         from_move_q  <= from_move_d;
         score_q      <= score_d;
         game_over_q  <= game_over_d;
         line_start_q <= line_start_d;
         line_idx_q   <= line_idx_d;
         clear_q      <= clear_d;
         spawn_we_q   <= spawn_we_d;
         spawn_idx_q  <= spawn_idx_d;
         spawn_four_q <= spawn_four_d;
         busy_q       <= busy_d;
         move_done_q  <= move_done_d;
         move_valid_q <= move_valid_d;
      end
   end

   assign bus.line_start  = line_start_q;
   assign bus.line_idx    = line_idx_q;
   assign bus.line_dir    = dir_q;
   assign bus.clear_board = clear_q;
   assign bus.spawn_we    = spawn_we_q;
   assign bus.spawn_idx   = spawn_idx_q;
   assign bus.spawn_four  = spawn_four_q;
   assign bus.score       = score_q;
   assign bus.busy        = busy_q;
   assign bus.move_done   = move_done_q;
   assign bus.move_valid  = move_valid_q;
   assign bus.game_over   = game_over_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with a zero-latency line engine and a
// board-mask model driven by clear_board/spawn_we.
module tb_game_sequencer;

   localparam logic [15:0] Seed = 16'hACE1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   game_sequencer_if bus ();

   game_sequencer #(.LFSR_SEED(Seed)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int passes = 0;

   logic [16:0] eng_score [4];
   logic        eng_chg   [4];
   logic        engine_en = 1'b1;
   logic        mask_load = 1'b0;
   logic [15:0] mask_val  = 16'hFFFF;

   logic [15:0] m_lfsr  = Seed;
   int          cyc     = 0;
   logic [3:0]  exp_idx = 4'd0;
   logic        exp_four = 1'b0;

   int          n_ls = 0, n_sp = 0, n_md = 0, n_clr = 0;
   logic [7:0]  ls_hist = 8'd0;
   logic [1:0]  ls_dir_last = 2'd0;
   int          ls0_cyc = 0, md_cyc = 0;
   logic        md_valid_last = 1'b0;
   logic [3:0]  sp_idx_last = 4'd0, sp_idx_prev = 4'd0, sp_exp_last = 4'd0;
   logic        sp_four_last = 1'b0, sp_four_exp = 1'b0;

   function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
      logic [15:0] n;
      n = {1'b0, v[15:1]};
      if (v[0]) n = n ^ 16'hB400;
      return n;
   endfunction

   function automatic logic [3:0] scan(input logic [15:0] m, input logic [3:0] s);
      for (int k = 0; k < 16; k++) begin
         if (m[(int'(s) + k) % 16]) return 4'((int'(s) + k) % 16);
      end
      return 4'd0;
   endfunction

   // Line engine: answers each line_start on the following cycle.
   always @(posedge clk) begin
      bus.line_done <= 1'b0;
      if (bus.line_start && engine_en) begin
         bus.line_done    <= 1'b1;
         bus.line_changed <= eng_chg[bus.line_idx];
         bus.line_score   <= eng_score[bus.line_idx];
      end
   end

   // Board model, reference LFSR and output monitors.
   always @(posedge clk) begin
      cyc      <= cyc + 1;
      m_lfsr   <= rst ? Seed : lfsr_adv(m_lfsr);
      exp_idx  <= scan(bus.empty_mask, m_lfsr[3:0]);
      exp_four <= (m_lfsr[7:4] == 4'd0);
      if (mask_load)            bus.empty_mask <= mask_val;
      else if (bus.clear_board) bus.empty_mask <= 16'hFFFF;
      else if (bus.spawn_we)    bus.empty_mask[bus.spawn_idx] <= 1'b0;
      if (bus.line_start) begin
         n_ls        <= n_ls + 1;
         ls_hist     <= {ls_hist[5:0], bus.line_idx};
         ls_dir_last <= bus.line_dir;
         if (bus.line_idx == 2'd0) ls0_cyc <= cyc;
      end
      if (bus.spawn_we) begin
         n_sp         <= n_sp + 1;
         sp_idx_prev  <= sp_idx_last;
         sp_idx_last  <= bus.spawn_idx;
         sp_exp_last  <= exp_idx;
         sp_four_last <= bus.spawn_four;
         sp_four_exp  <= exp_four;
      end
      if (bus.move_done) begin
         n_md          <= n_md + 1;
         md_cyc        <= cyc;
         md_valid_last <= bus.move_valid;
      end
      if (bus.clear_board) n_clr <= n_clr + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_engine(input logic [16:0] s0, input logic [16:0] s1,
                             input logic [16:0] s2, input logic [16:0] s3,
                             input logic [3:0] chg);
      eng_score[0] = s0; eng_score[1] = s1; eng_score[2] = s2; eng_score[3] = s3;
      for (int i = 0; i < 4; i++) eng_chg[i] = chg[i];
   endtask

   task automatic do_move(input logic [1:0] dir);
      bus.move_req = 1'b1;
      bus.move_dir = dir;
      @(negedge clk);
      bus.move_req = 1'b0;
      cycles(20);
   endtask

   task automatic do_new_game();
      bus.new_game = 1'b1;
      @(negedge clk);
      bus.new_game = 1'b0;
      cycles(14);
   endtask

   task automatic load_mask(input logic [15:0] v);
      mask_val  = v;
      mask_load = 1'b1;
      @(negedge clk);
      mask_load = 1'b0;
   endtask

   int s_ls, s_sp, s_md, s_clr;
   task automatic snap();
      s_ls = n_ls; s_sp = n_sp; s_md = n_md; s_clr = n_clr;
   endtask

   logic [15:0] ahead;
   logic        found;

   initial begin
      rst = 1'b1;
      bus.new_game = 1'b0;
      bus.move_req = 1'b0;
      bus.move_dir = 2'd0;
      bus.merge_possible = 1'b0;
      set_engine(17'd0, 17'd0, 17'd0, 17'd0, 4'b0000);
      mask_val  = 16'hFFFF;
      mask_load = 1'b1;
      cycles(3);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_score", bus.score, 21'd0);
      chk("rst_game_over", bus.game_over, 1'b0);
      chk("rst_strobes", {bus.line_start, bus.spawn_we, bus.clear_board, bus.move_done}, 4'b0);
      rst = 1'b0;
      mask_load = 1'b0;
      cycles(2);

      // New game timed so the first spawn sees lfsr[3:0] == 5.
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         ahead = lfsr_adv(lfsr_adv(m_lfsr));
         if (ahead[3:0] == 4'd5) found = 1'b1;
         else @(negedge clk);
      end
      chk("ng_align", found, 1'b1);
      snap();
      do_new_game();
      chk("ng_clear", n_clr - s_clr, 1);
      chk("ng_spawns", n_sp - s_sp, 2);
      chk("ng_idx0", sp_idx_prev, 4'd5);
      chk("ng_idx1", sp_idx_last, sp_exp_last);
      chk("ng_idx_differ", (sp_idx_last != 4'd5), 1'b1);
      chk("ng_four", sp_four_last, sp_four_exp);
      chk("ng_no_done", n_md - s_md, 0);
      chk("ng_idle", bus.busy, 1'b0);

      // Unchanged move: four lines, no spawn, 8-cycle latency.
      set_engine(17'd0, 17'd0, 17'd0, 17'd0, 4'b0000);
      snap();
      do_move(2'b01);
      chk("nc_lines", n_ls - s_ls, 4);
      chk("nc_idx_seq", ls_hist, 8'h1B);
      chk("nc_dir", ls_dir_last, 2'b01);
      chk("nc_done", n_md - s_md, 1);
      chk("nc_valid", md_valid_last, 1'b0);
      chk("nc_no_spawn", n_sp - s_sp, 0);
      chk("nc_latency", md_cyc - ls0_cyc, 8);

      // Scoring move with one changed line.
      set_engine(17'd4, 17'd8, 17'd0, 17'd16, 4'b0010);
      snap();
      do_move(2'b10);
      chk("sc_score", bus.score, 21'd28);
      chk("sc_spawn", n_sp - s_sp, 1);
      chk("sc_idx", sp_idx_last, sp_exp_last);
      chk("sc_valid", md_valid_last, 1'b1);
      chk("sc_done", n_md - s_md, 1);
      chk("sc_dir", ls_dir_last, 2'b10);

      // Saturation: 16 lines of 1FFFF reach 1FFFF0, then +64 clips.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("sat_rst_score", bus.score, 21'd0);
      set_engine(17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 4'b0000);
      for (int m = 0; m < 4; m++) do_move(2'b11);
      chk("sat_pre", bus.score, 21'h1FFFF0);
      set_engine(17'd64, 17'd0, 17'd0, 17'd0, 4'b0000);
      do_move(2'b00);
      chk("sat_clip", bus.score, 21'h1FFFFF);

      // Full board, merges still possible: no write, not game over.
      load_mask(16'h0000);
      bus.merge_possible = 1'b1;
      set_engine(17'd0, 17'd0, 17'd0, 17'd0, 4'b0001);
      snap();
      do_move(2'b00);
      chk("full_no_spawn", n_sp - s_sp, 0);
      chk("full_valid", md_valid_last, 1'b1);
      chk("full_not_over", bus.game_over, 1'b0);

      // Last empty cell filled with no merges -> game over.
      load_mask(16'h0100);
      bus.merge_possible = 1'b0;
      snap();
      do_move(2'b01);
      chk("go_spawn", n_sp - s_sp, 1);
      chk("go_idx", sp_idx_last, 4'd8);
      chk("go_flag", bus.game_over, 1'b1);
      snap();
      do_move(2'b01);
      chk("go_ignored_lines", n_ls - s_ls, 0);
      chk("go_ignored_busy", bus.busy, 1'b0);
      chk("go_sticky", bus.game_over, 1'b1);
      do_new_game();
      chk("go_cleared", bus.game_over, 1'b0);
      chk("go_clear_pulse", n_clr - s_clr, 1);
      chk("go_ng_score", bus.score, 21'd0);

      // Reset while waiting on the engine.
      set_engine(17'd4, 17'd0, 17'd0, 17'd0, 4'b0000);
      do_move(2'b00);
      chk("rw_score_pre", bus.score, 21'd4);
      snap();
      engine_en = 1'b0;
      bus.move_req = 1'b1;
      bus.move_dir = 2'b10;
      @(negedge clk);
      bus.move_req = 1'b0;
      cycles(3);
      chk("rw_stuck_busy", bus.busy, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rw_busy", bus.busy, 1'b0);
      chk("rw_score", bus.score, 21'd0);
      engine_en = 1'b1;
      cycles(10);
      chk("rw_no_done", n_md - s_md, 0);
      set_engine(17'd0, 17'd0, 17'd0, 17'd0, 4'b0000);
      do_move(2'b11);
      chk("rw_restart_seq", ls_hist, 8'h1B);
      chk("rw_restart_done", n_md - s_md, 1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
